// File: rtl/ddr3_mc_cmd_arb_pkg.sv
// rtl/ddr3_mc_cmd_arb_pkg.sv - shared state encoding, id width and sizing helper for the command arbiter
package ddr3_arb_pkg;

  localparam int ID_W = 4;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_ARB    = 5'b00010,
    ST_WRADDR = 5'b00100,
    ST_RDADDR = 5'b01000,
    ST_GAP    = 5'b10000
  } arb_state_e;

  // Never returns less than 1 so a single-channel index still has a bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/ddr3_mc_cmd_arb_rr_pick.sv
// rtl/ddr3_mc_cmd_arb_rr_pick.sv - first requesting channel at or above a start pointer, wrapping modulo N
module rr_pick
  import ddr3_arb_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] start_i,
  output logic [IW-1:0] grant_o,
  output logic          valid_o
);

  logic [IW-1:0] idx;

  // Walk from the farthest offset down so the nearest requester is the last write.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = IW'((int'(start_i) + k) % N);
      if (req_i[idx]) begin
        grant_o = idx;
        valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr3_mc_cmd_arb.sv
// rtl/ddr3_mc_cmd_arb.sv - read/write AXI command arbiter with round-robin channels and a post-command gap
module ddr3_mc_cmd_arb
  import ddr3_arb_pkg::*;
#(
  parameter int NUM_WR    = 2,
  parameter int NUM_RD    = 2,
  parameter int ADDR_W    = 28,
  parameter int BURST_LEN = 15,
  parameter int GAP_CYC   = 10,
  parameter bit WR_STRICT = 1'b0
) (
  input  logic                     clk_100M,
  input  logic                     rst,
  input  logic                     ddr_init_done,
  input  logic [NUM_WR-1:0]        wr_empty,
  input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
  output logic [NUM_WR-1:0]        wr_ref,
  input  logic [NUM_RD-1:0]        rd_empty,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_ref,
  output logic [ADDR_W-1:0]        axi_awaddr,
  output logic [3:0]               axi_awlen,
  output logic [ID_W-1:0]          axi_awid,
  output logic                     axi_awvalid,
  input  logic                     axi_awready,
  output logic [ADDR_W-1:0]        axi_araddr,
  output logic [3:0]               axi_arlen,
  output logic [ID_W-1:0]          axi_arid,
  output logic                     axi_arvalid,
  input  logic                     axi_arready,
  output logic                     busy
);

  localparam int WIW = clog2(NUM_WR);
  localparam int RIW = clog2(NUM_RD);
  localparam int GW  = clog2(GAP_CYC);

  arb_state_e        state_q, state_d;
  logic              init_q;
  logic              prior_wr_q;
  logic [WIW-1:0]    wr_ptr_q, wr_ch_q, wr_pick;
  logic [RIW-1:0]    rd_ptr_q, rd_ch_q, rd_pick;
  logic              wr_any, rd_any;
  logic [ADDR_W-1:0] awaddr_q, araddr_q;
  logic [NUM_WR-1:0] wr_ref_q;
  logic [NUM_RD-1:0] rd_ref_q;
  logic [GW-1:0]     gap_q;
  logic              aw_hs, ar_hs, wr_grant, rd_grant;

  rr_pick #(.N(NUM_WR)) u_wr_pick (
    .req_i   (~wr_empty),
    .start_i (wr_ptr_q),
    .grant_o (wr_pick),
    .valid_o (wr_any)
  );

  rr_pick #(.N(NUM_RD)) u_rd_pick (
    .req_i   (~rd_empty),
    .start_i (rd_ptr_q),
    .grant_o (rd_pick),
    .valid_o (rd_any)
  );

  assign aw_hs    = (state_q == ST_WRADDR) && axi_awready;
  assign ar_hs    = (state_q == ST_RDADDR) && axi_arready;
  assign wr_grant = (state_q == ST_ARB) && (state_d == ST_WRADDR);
  assign rd_grant = (state_q == ST_ARB) && (state_d == ST_RDADDR);

  // Calibration status crosses in from the DDR IP; one flop is all it gets.
  always_ff @(posedge clk_100M) begin
    init_q <= ddr_init_done;
  end

  always_ff @(posedge clk_100M) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (init_q) state_d = ST_ARB;
      ST_ARB: begin
        if (WR_STRICT) begin
          if (wr_any)      state_d = ST_WRADDR;
          else if (rd_any) state_d = ST_RDADDR;
        end else if (prior_wr_q && wr_any) state_d = ST_WRADDR;
        else if (rd_any)                   state_d = ST_RDADDR;
        else if (wr_any)                   state_d = ST_WRADDR;
      end
      ST_WRADDR: if (axi_awready) state_d = ST_GAP;
      ST_RDADDR: if (axi_arready) state_d = ST_GAP;
      ST_GAP:    if (gap_q == '0) state_d = init_q ? ST_ARB : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    axi_awvalid = (state_q == ST_WRADDR);
    axi_arvalid = (state_q == ST_RDADDR);
    busy        = (state_q == ST_WRADDR) || (state_q == ST_RDADDR) || (state_q == ST_GAP);
  end

  // Pointers hold the next channel to search from, so reset starts at channel 0.
  always_ff @(posedge clk_100M) begin
    if (rst) begin
      prior_wr_q <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wr_ch_q    <= '0;
      rd_ch_q    <= '0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wr_ref_q   <= '0;
      rd_ref_q   <= '0;
      gap_q      <= '0;
    end else begin
      wr_ref_q <= '0;
      rd_ref_q <= '0;
      if (wr_grant) begin
        wr_ch_q  <= wr_pick;
        awaddr_q <= wr_addr[int'(wr_pick)*ADDR_W +: ADDR_W];
      end
      if (rd_grant) begin
        rd_ch_q  <= rd_pick;
        araddr_q <= rd_addr[int'(rd_pick)*ADDR_W +: ADDR_W];
      end
      if (aw_hs) begin
        wr_ref_q[wr_ch_q] <= 1'b1;
        wr_ptr_q          <= (int'(wr_ch_q) == NUM_WR - 1) ? '0 : wr_ch_q + 1'b1;
        prior_wr_q        <= 1'b0;
      end
      if (ar_hs) begin
        rd_ref_q[rd_ch_q] <= 1'b1;
        rd_ptr_q          <= (int'(rd_ch_q) == NUM_RD - 1) ? '0 : rd_ch_q + 1'b1;
        prior_wr_q        <= 1'b1;
      end
      if (aw_hs || ar_hs)                      gap_q <= GW'(GAP_CYC - 1);
      else if (state_q == ST_GAP && gap_q != '0) gap_q <= gap_q - 1'b1;
    end
  end

  assign wr_ref     = wr_ref_q;
  assign rd_ref     = rd_ref_q;
  assign axi_awaddr = awaddr_q;
  assign axi_araddr = araddr_q;
  assign axi_awid   = ID_W'(wr_ch_q);
  assign axi_arid   = ID_W'(rd_ch_q);
  assign axi_awlen  = 4'(BURST_LEN);
  assign axi_arlen  = 4'(BURST_LEN);

endmodule

// File: tb/tb_ddr3_mc_cmd_arb.sv
// tb/tb_ddr3_mc_cmd_arb.sv - randomized bench for ddr3_mc_cmd_arb checked against a behavioural model
module tb_ddr3_mc_cmd_arb;

  localparam int N   = 2;
  localparam int AW  = 28;
  localparam int GAP = 10;
  localparam int BL  = 15;

  logic clk_100M = 1'b0;
  always #5 clk_100M = ~clk_100M;

  logic          rst = 1'b1;
  logic          ddr_init_done = 1'b0;
  logic [N-1:0]    wr_empty [2];
  logic [N*AW-1:0] wr_addr  [2];
  logic [N-1:0]    wr_ref   [2];
  logic [N-1:0]    rd_empty [2];
  logic [N*AW-1:0] rd_addr  [2];
  logic [N-1:0]    rd_ref   [2];
  logic [AW-1:0]   awaddr [2], araddr [2];
  logic [3:0]      awlen [2], arlen [2], awid [2], arid [2];
  logic            awvalid [2], arvalid [2], awready [2], arready [2], busy [2];

  ddr3_mc_cmd_arb #(.NUM_WR(N), .NUM_RD(N), .ADDR_W(AW), .BURST_LEN(BL), .GAP_CYC(GAP), .WR_STRICT(1'b0)) u_dut_alt (
    .clk_100M(clk_100M), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_empty(wr_empty[0]), .wr_addr(wr_addr[0]), .wr_ref(wr_ref[0]),
    .rd_empty(rd_empty[0]), .rd_addr(rd_addr[0]), .rd_ref(rd_ref[0]),
    .axi_awaddr(awaddr[0]), .axi_awlen(awlen[0]), .axi_awid(awid[0]),
    .axi_awvalid(awvalid[0]), .axi_awready(awready[0]),
    .axi_araddr(araddr[0]), .axi_arlen(arlen[0]), .axi_arid(arid[0]),
    .axi_arvalid(arvalid[0]), .axi_arready(arready[0]), .busy(busy[0])
  );

  ddr3_mc_cmd_arb #(.NUM_WR(N), .NUM_RD(N), .ADDR_W(AW), .BURST_LEN(BL), .GAP_CYC(GAP), .WR_STRICT(1'b1)) u_dut_strict (
    .clk_100M(clk_100M), .rst(rst), .ddr_init_done(ddr_init_done),
    .wr_empty(wr_empty[1]), .wr_addr(wr_addr[1]), .wr_ref(wr_ref[1]),
    .rd_empty(rd_empty[1]), .rd_addr(rd_addr[1]), .rd_ref(rd_ref[1]),
    .axi_awaddr(awaddr[1]), .axi_awlen(awlen[1]), .axi_awid(awid[1]),
    .axi_awvalid(awvalid[1]), .axi_awready(awready[1]),
    .axi_araddr(araddr[1]), .axi_arlen(arlen[1]), .axi_arid(arid[1]),
    .axi_arvalid(arvalid[1]), .axi_arready(arready[1]), .busy(busy[1])
  );

  // Channel FIFOs, index d*N+c, shared by the stimulus and the model.
  logic [AW-1:0] wq [2*N][$];
  logic [AW-1:0] rq [2*N][$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Behavioural model: one outstanding command, a gap countdown, and a flag for "may arbitrate".
  bit            m_cmd_v [2], m_cmd_wr [2], m_arb [2], m_prior_wr [2];
  int            m_cmd_ch [2], m_gap [2], m_wptr [2], m_rptr [2], m_awid [2], m_arid [2];
  logic [AW-1:0] m_awaddr [2], m_araddr [2];
  logic [N-1:0]  m_wref [2], m_rref [2];
  bit            m_init_q = 1'b0;

  task automatic m_reset(input int d);
    m_cmd_v[d] = 0; m_cmd_wr[d] = 0; m_cmd_ch[d] = 0; m_gap[d] = 0; m_arb[d] = 0;
    m_prior_wr[d] = 1; m_wptr[d] = 0; m_rptr[d] = 0; m_awid[d] = 0; m_arid[d] = 0;
    m_awaddr[d] = '0; m_araddr[d] = '0; m_wref[d] = '0; m_rref[d] = '0;
  endtask

  function automatic int first_pending(input int d, input bit is_wr, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (is_wr ? (wq[d*N+c].size() > 0) : (rq[d*N+c].size() > 0)) return c;
    end
    return -1;
  endfunction

  task automatic m_step(input int d);
    int  w, r;
    bit  go_wr, go_rd;
    m_wref[d] = '0;
    m_rref[d] = '0;
    if (rst) begin
      m_reset(d);
    end else if (m_cmd_v[d]) begin
      if (m_cmd_wr[d] ? awready[d] : arready[d]) begin
        if (m_cmd_wr[d]) begin
          m_wref[d][m_cmd_ch[d]] = 1'b1; m_wptr[d] = (m_cmd_ch[d] + 1) % N; m_prior_wr[d] = 0;
        end else begin
          m_rref[d][m_cmd_ch[d]] = 1'b1; m_rptr[d] = (m_cmd_ch[d] + 1) % N; m_prior_wr[d] = 1;
        end
        m_cmd_v[d] = 0;
        m_gap[d]   = GAP;
      end
    end else if (m_gap[d] > 0) begin
      m_gap[d]--;
      if (m_gap[d] == 0) m_arb[d] = m_init_q;
    end else if (m_arb[d]) begin
      w = first_pending(d, 1'b1, m_wptr[d]);
      r = first_pending(d, 1'b0, m_rptr[d]);
      if (d == 1) go_wr = (w >= 0);
      else        go_wr = (w >= 0) && (m_prior_wr[d] || r < 0);
      go_rd = !go_wr && (r >= 0);
      if (go_wr) begin
        m_cmd_v[d] = 1; m_cmd_wr[d] = 1; m_cmd_ch[d] = w; m_arb[d] = 0;
        m_awaddr[d] = wq[d*N+w][0]; m_awid[d] = w;
      end else if (go_rd) begin
        m_cmd_v[d] = 1; m_cmd_wr[d] = 0; m_cmd_ch[d] = r; m_arb[d] = 0;
        m_araddr[d] = rq[d*N+r][0]; m_arid[d] = r;
      end
    end else if (m_init_q) begin
      m_arb[d] = 1;
    end
  endtask

  task automatic check_outputs(input int d);
    string p;
    p = (d == 0) ? "alt" : "strict";
    check({p, " awvalid"}, 64'(awvalid[d]), 64'(m_cmd_v[d] && m_cmd_wr[d]));
    check({p, " arvalid"}, 64'(arvalid[d]), 64'(m_cmd_v[d] && !m_cmd_wr[d]));
    check({p, " awaddr"},  64'(awaddr[d]),  64'(m_awaddr[d]));
    check({p, " araddr"},  64'(araddr[d]),  64'(m_araddr[d]));
    check({p, " awid"},    64'(awid[d]),    64'(m_awid[d]));
    check({p, " arid"},    64'(arid[d]),    64'(m_arid[d]));
    check({p, " awlen"},   64'(awlen[d]),   64'(BL));
    check({p, " arlen"},   64'(arlen[d]),   64'(BL));
    check({p, " wr_ref"},  64'(wr_ref[d]),  64'(m_wref[d]));
    check({p, " rd_ref"},  64'(rd_ref[d]),  64'(m_rref[d]));
    check({p, " busy"},    64'(busy[d]),    64'(m_cmd_v[d] || m_gap[d] > 0));
  endtask

  int           push_w = 0, push_r = 0;
  logic [N-1:0] mask_w = '1, mask_r = '1;
  int           aw_mode = 0, ar_mode = 0;

  function automatic logic rdy(input int mode);
    if (mode == 0) return 1'b1;
    if (mode == 1) return ($urandom_range(0, 3) != 0);
    return 1'b0;
  endfunction

  task automatic drive();
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        wr_empty[d][c]          = (wq[d*N+c].size() == 0);
        rd_empty[d][c]          = (rq[d*N+c].size() == 0);
        wr_addr[d][c*AW +: AW]  = (wq[d*N+c].size() > 0) ? wq[d*N+c][0] : '0;
        rd_addr[d][c*AW +: AW]  = (rq[d*N+c].size() > 0) ? rq[d*N+c][0] : '0;
      end
  endtask

  // Check this cycle, let the FIFOs react to pops, then set inputs for the next edge and advance the model.
  task automatic cycle(input bit rst_v, input bit init_v);
    @(negedge clk_100M);
    for (int d = 0; d < 2; d++) check_outputs(d);
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) begin
        if (wr_ref[d][c] === 1'b1 && wq[d*N+c].size() > 0) void'(wq[d*N+c].pop_front());
        if (rd_ref[d][c] === 1'b1 && rq[d*N+c].size() > 0) void'(rq[d*N+c].pop_front());
      end
    rst           = rst_v;
    ddr_init_done = init_v;
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < N; c++) begin
        if (mask_w[c] && wq[d*N+c].size() < 4 && $urandom_range(0, 99) < push_w)
          wq[d*N+c].push_back(AW'($urandom));
        if (mask_r[c] && rq[d*N+c].size() < 4 && $urandom_range(0, 99) < push_r)
          rq[d*N+c].push_back(AW'($urandom));
      end
      awready[d] = rdy(aw_mode);
      arready[d] = rdy(ar_mode);
    end
    drive();
    for (int d = 0; d < 2; d++) m_step(d);
    m_init_q = ddr_init_done;
  endtask

  initial begin
    bit seen;
    for (int d = 0; d < 2; d++) begin
      m_reset(d);
      awready[d] = 1'b1;
      arready[d] = 1'b1;
    end
    drive();
    repeat (3) cycle(1'b1, 1'b0);

    // Writes pending on both channels but calibration not done yet.
    for (int d = 0; d < 2; d++)
      for (int c = 0; c < N; c++) wq[d*N+c].push_back(AW'($urandom));
    repeat (50) cycle(1'b0, 1'b0);

    push_w = 60; push_r = 60;
    repeat (250) cycle(1'b0, 1'b1);

    push_r = 0; aw_mode = 1;
    repeat (200) cycle(1'b0, 1'b1);

    mask_w = 2'b10; aw_mode = 0;
    repeat (150) cycle(1'b0, 1'b1);

    mask_w = '1; push_r = 40; aw_mode = 2; ar_mode = 2;
    repeat (30) cycle(1'b0, 1'b1);

    push_w = 20; push_r = 20; aw_mode = 1; ar_mode = 1;
    repeat (400) cycle(1'b0, 1'b1);

    repeat (60) cycle(1'b0, 1'b0);
    repeat (200) cycle(1'b0, 1'b1);

    push_w = 0; push_r = 50; aw_mode = 0; ar_mode = 0;
    repeat (300) cycle(1'b0, 1'b1);

    // Reset while a write command is stalled waiting for awready.
    push_w = 100; mask_w = 2'b01; push_r = 0; aw_mode = 2; ar_mode = 0;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      cycle(1'b0, 1'b1);
      seen = (awvalid[0] === 1'b1);
    end
    check("stalled awvalid before reset", 64'(seen), 64'(1));
    cycle(1'b1, 1'b1);
    mask_w = '1; push_w = 50; push_r = 50; aw_mode = 0;
    repeat (200) cycle(1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ddr3_mc_cmd_arb.md
Name: ddr3_mc_cmd_arb

Overview:
Next-generation DDR3 AXI command arbiter. It serves NUM_WR write-address sources and NUM_RD read-address sources; each source is a FIFO holding pending burst start addresses. The block alternates read and write priority, round-robins among channels of the same direction, and issues one AXI AW or AR command at a time. It then enforces a programmable inter-command gap. It sits between the per-stream frame-buffer address generators and the DDR3 IP AXI command ports.

Parameters:
NUM_WR, 2, number of write channels (1..8)
NUM_RD, 2, number of read channels (1..8)
ADDR_W, 28, AXI address width
BURST_LEN, 15, value driven on axi_awlen/axi_arlen (burst of BURST_LEN+1 beats)
GAP_CYC, 10, idle cycles after each handshake before re-arbitration (>=1)
WR_STRICT, 0, 0 = alternate read/write priority, 1 = writes always win

Ports:
clk_100M  in  1  system clock
rst  in  1  synchronous active-high reset
ddr_init_done  in  1  DDR3 IP calibration done (async to logic; registered once internally)
wr_empty  in  NUM_WR  per-channel write-address FIFO empty
wr_addr  in  NUM_WR*ADDR_W  per-channel FIFO output data; channel i occupies bits [i*ADDR_W +: ADDR_W]
wr_ref  out  NUM_WR  one-cycle pop/refresh pulse to channel FIFO
rd_empty  in  NUM_RD  per-channel read-address FIFO empty
rd_addr  in  NUM_RD*ADDR_W  same packing as wr_addr
rd_ref  out  NUM_RD  one-cycle pop pulse
axi_awaddr  out  ADDR_W  write command address
axi_awlen  out  4  = BURST_LEN
axi_awid  out  4  = granted write channel index
axi_awvalid  out  1  write command valid
axi_awready  in  1  IP ready
axi_araddr  out  ADDR_W  read command address
axi_arlen  out  4  = BURST_LEN
axi_arid  out  4  = granted read channel index
axi_arvalid  out  1  read command valid
axi_arready  in  1  IP ready
busy  out  1  high in any state except IDLE and ARB

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: all valid and ref outputs 0, addresses 0, ids 0, busy 0. State is IDLE, prior_wr=1, round-robin pointers 0.
- init_done is ddr_init_done delayed one cycle.
- States are IDLE, ARB, WRADDR, RDADDR, GAP. The encoding is one-hot.
- IDLE -> ARB when init_done=1.
- ARB: let anyw = |~wr_empty and anyr = |~rd_empty.
  - WR_STRICT=1: anyw -> WRADDR, else anyr -> RDADDR.
  - WR_STRICT=0: (prior_wr & anyw) -> WRADDR; else anyr -> RDADDR; else anyw -> WRADDR.
  - Neither pending: stay in ARB.
- Channel selection: the first non-empty channel searching upward from last_grant+1, modulo N. Channel index and address are latched at the ARB exit edge.
- WRADDR: axi_awvalid=1 from the first cycle in the state. Address and id are stable until the handshake.
  - On awvalid&awready, awvalid drops next cycle and wr_ref[ch] pulses exactly one cycle (the cycle after the handshake).
  - Next state is GAP; last_wr_grant<=ch; prior_wr<=0.
- RDADDR mirrors WRADDR (prior_wr<=1 on read handshake).
- A valid is never deasserted without a handshake, except by rst.
- GAP: counter loads GAP_CYC-1 on entry and decrements; at 0 -> ARB. At most one command is in flight overall.
- Channel FIFO empty flags that change while not in ARB are ignored until the next ARB.
- Simultaneous wr/rd pending follows the priority rules above. A single pending channel is regranted every round.
- If init_done falls, the current command completes and the block returns to IDLE from GAP instead of ARB.
- rst mid-handshake: all outputs are forced to reset values next edge; the pending pop is lost and the FIFO is not popped.

Decomposition:
- Package ddr3_arb_pkg holds the state encodings, ID width (4), and a clog2 helper function.
- Sub-module rr_pick (parameter N): combinational first-set search given a request vector and a start pointer, producing a grant index and a valid flag. It is instantiated once per direction.

Test Plan:
1. Init gating: ddr_init_done=0 with wr_empty=2'b00 for 50 cycles -> no awvalid. Assert init -> awvalid within 3 cycles with axi_awaddr=wr_addr[0].
2. Alternation: both directions pending continuously, awready/arready tied 1, GAP_CYC=10 -> commands alternate W,R,W,R. Consecutive handshakes are 12 cycles apart, and each handshake produces exactly one ref pulse.
3. Round-robin: wr channels 0 and 1 always non-empty, reads empty -> axi_awid sequence 0,1,0,1. A single request on channel 1 -> regranted 1,1,1.
4. Backpressure: hold awready=0 for 20 cycles -> awvalid stays 1 with stable address/id. wr_ref stays 0 until one cycle after awready=1.
5. WR_STRICT=1: both directions pending -> only writes issue until all wr_empty=1, then reads issue.
6. Reset mid-op: assert rst while awvalid=1 and awready=0 -> next edge awvalid=0, wr_ref=0, busy=0, state IDLE. Re-init restarts from channel 0.
